// File: rtl/pec_ram_rd_stream_if.sv
// pec_ram_rd_stream_if: control, SRAM read port and output stream bundle for pec_ram_rd_stream
interface pec_ram_rd_stream_if #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH = 28
);
  logic start;
  logic [SRAM_DEPTH_BIT-1:0] base_addr;
  logic [SRAM_DEPTH_BIT:0] num_words;
  logic busy;
  logic done;
  logic [SRAM_DEPTH_BIT-1:0] ram_addr_r;
  logic ram_read_en;
  logic ram_busy_rd;
  logic [SRAM_WIDTH-1:0] ram_data_out;
  logic out_valid;
  logic out_ready;
  logic [SRAM_WIDTH-1:0] out_data;
  logic out_last;
  logic [15:0] stall_cnt;
  modport master (
    input start, base_addr, num_words, ram_busy_rd, ram_data_out, out_ready,
    output busy, done, ram_addr_r, ram_read_en, out_valid, out_data, out_last, stall_cnt
  );
  modport slave (
    output start, base_addr, num_words, ram_busy_rd, ram_data_out, out_ready,
    input busy, done, ram_addr_r, ram_read_en, out_valid, out_data, out_last, stall_cnt
  );
endinterface

// File: rtl/pec_ram_rd_stream.sv
// pec_ram_rd_stream: burst SRAM read sequencer with credit-limited output FIFO; PEC_RD_STALL_CNT_EN enables the conflict-stall counter
module pec_ram_rd_stream #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH = 28,
  parameter int FIFO_DEPTH_BIT = 2
) (
  input logic clk,
  input logic reset,
  pec_ram_rd_stream_if.master bus
);
  localparam int FD = 1 << FIFO_DEPTH_BIT;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state, state_nx;
  logic [SRAM_DEPTH_BIT-1:0] addr;
  logic [SRAM_DEPTH_BIT:0] remaining;
  logic read_en_d, last_d, empty_done;
  logic [SRAM_WIDTH:0] mem [FD];
  logic [FIFO_DEPTH_BIT-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_BIT:0] count;
  logic accept, issue, final_issue, push, pop, head_last, last_pop;
  // issue credit check and next-state selection
  always_comb begin
    accept = (state == IDLE) && bus.start;
    issue = (state == READ) && !bus.ram_busy_rd &&
            ((FIFO_DEPTH_BIT+2)'(count) + (FIFO_DEPTH_BIT+2)'(read_en_d) < (FIFO_DEPTH_BIT+2)'(FD));
    final_issue = issue && (remaining == (SRAM_DEPTH_BIT+1)'(1));
    push = read_en_d;
    pop = (count != '0) && bus.out_ready;
    head_last = mem[rd_ptr][SRAM_WIDTH];
    last_pop = pop && head_last;
    state_nx = state == IDLE ? ((accept && bus.num_words != '0) ? READ : IDLE) :
               state == READ ? (final_issue ? DRAIN : READ) :
               (last_pop ? IDLE : DRAIN);
  end
  assign bus.ram_read_en = issue;
  assign bus.ram_addr_r = addr;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = count != '0;
  assign bus.out_data = (count != '0) ? mem[rd_ptr][SRAM_WIDTH-1:0] : '0;
  assign bus.out_last = (count != '0) && head_last;
  assign bus.done = empty_done || ((state == DRAIN) && last_pop);
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // read pointer, remaining count, return pipeline and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      remaining <= '0;
      read_en_d <= 1'b0;
      last_d <= 1'b0;
      empty_done <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      empty_done <= accept && bus.num_words == '0;
      if (accept) begin
        addr <= bus.base_addr;
        remaining <= bus.num_words;
      end else if (issue) begin
        addr <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      read_en_d <= issue;
      last_d <= final_issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FIFO_DEPTH_BIT+1)'(push) - (FIFO_DEPTH_BIT+1)'(pop);
    end
  end
  // FIFO storage, tagged with the last-word flag
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last_d, bus.ram_data_out};
  end
`ifdef PEC_RD_STALL_CNT_EN
  logic [15:0] stall;
  // saturating count of READ cycles lost to write conflicts
  always_ff @(posedge clk) begin
    if (reset || accept) stall <= '0;
    else if (state == READ && bus.ram_busy_rd && stall != 16'hFFFF) stall <= stall + 1'b1;
  end
  assign bus.stall_cnt = stall;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pec_ram_rd_stream.sv
// tb_pec_ram_rd_stream: cycle-vector table plus backpressure and mid-burst reset sequences
module tb_pec_ram_rd_stream;
  localparam int DB = 6;
  localparam int W = 28;
`ifdef PEC_RD_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pec_ram_rd_stream_if #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W)) bus ();
  pec_ram_rd_stream #(.SRAM_DEPTH_BIT(DB), .SRAM_WIDTH(W), .FIFO_DEPTH_BIT(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  function automatic logic [W-1:0] f(input logic [DB-1:0] a);
    return 28'h5A50000 + W'(a) * 28'h101;
  endfunction
  // SRAM model with one-cycle read latency
  always @(posedge clk) bus.ram_data_out <= bus.ram_read_en ? f(bus.ram_addr_r) : '0;
  typedef struct {
    logic st; logic [5:0] base; logic [6:0] num; logic brd; logic rdy;
    logic re; logic [5:0] addr; logic val; logic [5:0] w; logic last; logic done; logic busy; logic [15:0] stall;
  } vec_t;
  vec_t v[$];
  int tests = 0;
  int fails = 0;
  function automatic void add(int st, int base, int num, int brd, int re, int addr, int val, int w,
                              int last, int done, int busy, int stall);
    vec_t e;
    e = '{1'(st), 6'(base), 7'(num), 1'(brd), 1'b1, 1'(re), 6'(addr), 1'(val), 6'(w),
          1'(last), 1'(done), 1'(busy), 16'(stall)};
    v.push_back(e);
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({bus.ram_read_en, bus.ram_addr_r, bus.out_valid, bus.out_data, bus.out_last,
                bus.done, bus.busy, bus.stall_cnt});
  endfunction
  initial begin
    logic [W-1:0] ed;
    int issued, got;
    bit done_seen, seen;
    bus.start = 0; bus.base_addr = '0; bus.num_words = '0; bus.ram_busy_rd = 0; bus.out_ready = 1;
    // basic burst 5..8
    add(1, 5, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 7, 1, 5, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 8, 1, 6, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 9, 1, 7, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 9, 1, 8, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0);
    // same burst with conflicts on T+2, T+3
    add(1, 5, 4, 0, 0, 9, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 6, 1, 5, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 1, 8, 1, 6, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 9, 1, 7, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 9, 1, 8, 1, 1, 1, 2);
    add(0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 2);
    // address wrap 62,63,0,1
    add(1, 62, 4, 0, 0, 9, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 62, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 63, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 62, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 63, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 2, 1, 1, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    // empty burst
    add(1, 10, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", outs(), 64'd0);
    reset = 0;
    foreach (v[i]) begin
      @(negedge clk);
      bus.start = v[i].st; bus.base_addr = v[i].base; bus.num_words = v[i].num;
      bus.ram_busy_rd = v[i].brd; bus.out_ready = v[i].rdy;
      #1;
      ed = v[i].val ? f(v[i].w) : '0;
      check($sformatf("vec%0d", i), outs(),
            64'({v[i].re, v[i].addr, v[i].val, ed, v[i].last, v[i].done, v[i].busy,
                 STALL_EN ? v[i].stall : 16'd0}));
    end
    // backpressure: 10 words, ready low for 10 cycles
    @(negedge clk);
    bus.start = 1; bus.base_addr = 6'd20; bus.num_words = 7'd10; bus.ram_busy_rd = 0; bus.out_ready = 0;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.start = 0;
      #1 issued += int'(bus.ram_read_en);
    end
    check("bp_issued", 64'(issued), 64'd4);
    check("bp_fifo_head", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, f(6'd20)}));
    got = 0;
    done_seen = 0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      @(negedge clk);
      bus.out_ready = 1;
      #1;
      if (bus.out_valid) begin
        check($sformatf("bp_word%0d", got), 64'({bus.out_data, bus.out_last}), 64'({f(6'(20 + got)), got == 9}));
        got++;
      end
      if (bus.done) begin
        done_seen = 1;
        check("bp_done_on_10th", 64'(got), 64'd10);
      end
    end
    check("bp_done_seen", 64'(done_seen), 64'd1);
    check("bp_word_count", 64'(got), 64'd10);
    @(negedge clk);
    #1 check("bp_idle_after", 64'({bus.busy, bus.out_valid}), 64'd0);
    // reset after two reads
    @(negedge clk);
    bus.start = 1; bus.base_addr = 6'd40; bus.num_words = 7'd8; bus.out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      bus.start = 0;
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1 check("rst_mid_outputs", outs(), 64'd0);
    reset = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1 seen |= bus.out_valid;
    end
    check("rst_no_stale_word", 64'(seen), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
